// File: rtl/display_shift_scheduler_if.sv
// Requester-side handshake bundle for display_shift_scheduler: enable, two valid/ready/data requesters.
interface display_shift_scheduler_if #(
    parameter int unsigned SHIFT_WIDTH = 48
) ();
    logic                   i_en;
    logic                   i_a_valid;
    logic [SHIFT_WIDTH-1:0] i_a_data;
    logic                   o_a_ready;
    logic                   i_b_valid;
    logic [SHIFT_WIDTH-1:0] i_b_data;
    logic                   o_b_ready;

    modport master (
        output i_en, i_a_valid, i_a_data, i_b_valid, i_b_data,
        input  o_a_ready, o_b_ready
    );

    modport slave (
        input  i_en, i_a_valid, i_a_data, i_b_valid, i_b_data,
        output o_a_ready, o_b_ready
    );
endinterface

// File: rtl/display_shift_scheduler.sv
// Round-robin A/B frame scheduler that shifts a frame MSB-first on a divided serial clock, then latches.
// Optional SHIFT_SKIP_DUP_EN: frames identical to the last latched frame are acknowledged but not shifted.
module display_shift_scheduler #(
    parameter int unsigned SYS_CLK_HZ   = 50_000_000,
    parameter int unsigned SHIFT_CLK_HZ = 1_000_000,
    parameter int unsigned SHIFT_WIDTH  = 48
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    display_shift_scheduler_if.slave    bus,
    output logic                        o_serial_data,
    output logic                        o_serial_clk,
    output logic                        o_serial_latch,
    output logic                        o_busy,
    output logic                        o_last_grant
);

    localparam int unsigned HALF  = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
    localparam int unsigned CNT_W = $clog2(HALF + 1);
    localparam int unsigned IDX_W = $clog2(SHIFT_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(SHIFT_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SHIFT_WIDTH-1:0] frame_q, frame_d;
    logic                   last_grant_q, last_grant_d;
    logic                   sdata_q, sdata_d;
    logic                   sclk_q, sclk_d;
    logic                   latch_q, latch_d;
    logic                   busy_q, busy_d;
`ifdef SHIFT_SKIP_DUP_EN
    logic [SHIFT_WIDTH-1:0] shadow_q, shadow_d;
    logic                   shadow_vld_q, shadow_vld_d;
`endif

    logic                   grant_a_c;
    logic                   grant_b_c;
    logic                   accept_c;
    logic                   phase_done_c;
    logic [SHIFT_WIDTH-1:0] accept_data_c;

    // Round-robin grant; ready is only ever offered from IDLE and never while reset is asserted.
    always_comb begin
        grant_a_c     = (state_q == ST_IDLE) & i_reset_n & bus.i_en & bus.i_a_valid
                        & (~bus.i_b_valid | last_grant_q);
        grant_b_c     = (state_q == ST_IDLE) & i_reset_n & bus.i_en & bus.i_b_valid & ~grant_a_c;
        accept_c      = grant_a_c | grant_b_c;
        accept_data_c = grant_a_c ? bus.i_a_data : bus.i_b_data;
        phase_done_c  = (cnt_q == CNT_LAST);
    end

    assign bus.o_a_ready = grant_a_c;
    assign bus.o_b_ready = grant_b_c;

    // Next-state logic; serial outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        last_grant_d = last_grant_q;
`ifdef SHIFT_SKIP_DUP_EN
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    frame_d      = accept_data_c;
                    idx_d        = IDX_MSB;
                    cnt_d        = '0;
                    last_grant_d = grant_b_c;
                    state_d      = ST_SHIFT_LO;
`ifdef SHIFT_SKIP_DUP_EN
                    if (shadow_vld_q && (accept_data_c == shadow_q)) begin
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
            ST_SHIFT_LO: begin
                if (phase_done_c) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (phase_done_c) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = ST_LATCH;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = ST_SHIFT_LO;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                if (phase_done_c) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
`ifdef SHIFT_SKIP_DUP_EN
                    shadow_d     = frame_q;
                    shadow_vld_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sclk_d  = (state_d == ST_SHIFT_HI);
        latch_d = (state_d == ST_LATCH);
        busy_d  = (state_d != ST_IDLE);
        sdata_d = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ? frame_d[idx_d] : 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_q      <= '0;
            last_grant_q <= 1'b1;
            sdata_q      <= 1'b0;
            sclk_q       <= 1'b0;
            latch_q      <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SHIFT_SKIP_DUP_EN
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            last_grant_q <= last_grant_d;
            sdata_q      <= sdata_d;
            sclk_q       <= sclk_d;
            latch_q      <= latch_d;
            busy_q       <= busy_d;
`ifdef SHIFT_SKIP_DUP_EN
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
`endif
        end
    end

    assign o_serial_data  = sdata_q;
    assign o_serial_clk   = sclk_q;
    assign o_serial_latch = latch_q;
    assign o_busy         = busy_q;
    assign o_last_grant   = last_grant_q;

endmodule

// File: doc/display_shift_scheduler.md
# display_shift_scheduler

Sequencing controller for the clock's 48-bit serial display chain: SHIFT_WIDTH bits shifted MSB-first on a serial clock, followed by a latch strobe. It arbitrates between two frame requesters (A: time/date display path, B: set-mode or diagnostic overlay) using round-robin order. It captures the granted frame, generates the serial clock from the system clock, shifts the frame out and pulses the latch. It sits between the clock core and the output pins o_serial_data / o_serial_clk / o_serial_latch.

## Interface
- SYS_CLK_HZ, 50_000_000, system clock frequency
- SHIFT_CLK_HZ, 1_000_000, serial clock frequency; HALF = SYS_CLK_HZ/(2*SHIFT_CLK_HZ), integer division, must be ≥1 (25 at defaults)
- SHIFT_WIDTH, 48, frame width in bits (6 digits × 8 segments)

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  reset, asynchronous, active-low
- i_en  in  1  grants allowed when high; a frame in flight always completes
- i_a_valid  in  1  requester A has a frame
- i_a_data  in  SHIFT_WIDTH  requester A frame
- o_a_ready  out  1  A frame accepted this cycle when i_a_valid also high
- i_b_valid / i_b_data / o_b_ready  same as A, for requester B
- o_serial_data  out  1  serial bit, MSB first
- o_serial_clk  out  1  shift clock; receiver samples on rising edge
- o_serial_latch  out  1  latch strobe; receiver transfers on rising edge
- o_busy  out  1  high while not IDLE
- o_last_grant  out  1  0 = A served last, 1 = B served last

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE grant logic (combinational):
  - grant_a = i_en & i_a_valid & (!i_b_valid | o_last_grant)
  - grant_b = i_en & i_b_valid & !grant_a
  - o_x_ready = grant_x, only in IDLE.
- Accept (valid & ready): frame register ← data, bit index ← SHIFT_WIDTH-1, o_last_grant ← granted ID, go to SHIFT_LO.
- SHIFT_LO: o_serial_clk=0, o_serial_data=frame[index], held HALF cycles, then SHIFT_HI.
- SHIFT_HI: o_serial_clk=1, data unchanged, held HALF cycles.
  - If index==0, go to LATCH.
  - Else index−1, go to SHIFT_LO.
- LATCH: o_serial_clk=0, o_serial_data=0, o_serial_latch=1 for HALF cycles, then IDLE with latch low.
- Data never changes while o_serial_clk is high.
- Requester data may change after its ready cycle; the frame register is the only source used.
- Simultaneous valids: alternate, starting with A after reset.
- Single valid: served regardless of o_last_grant.
- i_en falling mid-frame: frame completes; no new grant until i_en is high in IDLE.
- Phase counter width $clog2(HALF+1); bit index width $clog2(SHIFT_WIDTH).

## Timing
- Reset values: o_serial_data=0, o_serial_clk=0, o_serial_latch=0, o_a_ready=0, o_b_ready=0, o_busy=0, o_last_grant=1 (A wins first tie). Frame register 0.
- Reset asserted mid-frame: all outputs go to reset values immediately. Partial frame discarded, no latch pulse.
- Accept at edge N: SHIFT_LO and MSB visible from N+1.
- First o_serial_clk rise at N+1+HALF.
- Latch high from N+1+SHIFT_WIDTH·2·HALF for HALF cycles.
- IDLE at N+1+(2·SHIFT_WIDTH+1)·HALF, which is N+2426 at defaults.
- Back-to-back: next accept possible in the first IDLE cycle. Minimum frame period (2·SHIFT_WIDTH+1)·HALF+1 cycles.
- Ready is asserted for at most one cycle per frame.

## Configuration
- SHIFT_SKIP_DUP_EN defined:
  - A shadow register holds the last latched frame, plus a shadow-valid flag cleared by reset.
  - An accepted frame equal to the shadow with the flag set completes its handshake but is not shifted. State stays IDLE, no serial/latch activity, o_last_grant still updates.
  - Shadow updates when LATCH completes.
- SHIFT_SKIP_DUP_EN undefined: no shadow logic; every accepted frame is shifted and latched.

## Test plan
- Reset, A sends 48'h3F06_5B4F_666D → shift-register model latches 48'h3F06_5B4F_666D; one latch pulse; o_busy high 2425 cycles.
- A and B valid together continuously with different frames → accepts alternate A, B, A, B; o_last_grant toggles 0,1,0,1.
- Only B valid with o_last_grant=1 → B accepted in first IDLE cycle.
- i_en dropped 100 cycles after accept → frame completes and latches; no ready while i_en low; resumes when i_en returns high.
- i_reset_n pulsed low mid-shift (bit 20) → outputs 0 asynchronously; no latch edge; latched model output unchanged; next frame correct.
- SHIFT_SKIP_DUP_EN: same frame sent twice → second handshake completes, no o_serial_clk edges, o_busy stays 0. Without the macro → two full frames shifted.
